// File: rtl/updown_mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the up/down modulo counter family:
//   direction encodings and the load-value clamp helper.
//   Used by updown_mod_counter (top) and updown_next (next-value logic).
// ---------------------------------------------------------------------------
package counter_pkg;

    // Direction encodings for the up_dn input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Widest counter supported; the clamp helper works at this width so it can
    // serve every legal WIDTH without being re-parameterised.
    localparam int CNT_MAX_WIDTH = 32;

    // Clamp a load value into the legal count range.
    // "val >= MODULUS" is evaluated as "val > MODULUS-1" so that the bound
    // always fits in 32 bits, even when MODULUS == 2**32.
    function automatic logic [31:0] clamp_load(
        input logic [31:0] val,
        input logic [31:0] max_val
    );
        logic [31:0] result;
        if (val > max_val) begin
            result = max_val;
        end else begin
            result = val;
        end
        return result;
    endfunction

endpackage : counter_pkg

// File: rtl/updown_mod_counter_next.sv
// ---------------------------------------------------------------------------
// updown_next
//   Purely combinational next-value generator for the up/down modulo counter.
//   Given the current count and direction it returns the value one step away
//   (wrapping at the modulus) and flags when the current count sits on the
//   bound it would wrap across (MODULUS-1 going up, 0 going down).
//   Arithmetic is carried out on WIDTH+1 bits so MODULUS == 2**WIDTH is safe.
// ---------------------------------------------------------------------------
module updown_next
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up_dn,
    output logic [WIDTH-1:0] o_next,
    output logic             o_at_bound
);

    // Extended-width constants: the top count is MODULUS-1, computed without
    // overflow because MODULUS itself fits in WIDTH+1 bits.
    localparam logic [WIDTH:0]   ONE_W  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ZERO_W = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]   MOD_W  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   MAX_W  = MOD_W - ONE_W;
    localparam logic [WIDTH-1:0] MAX_Q  = MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};

    logic [WIDTH:0] w_q_ext;

    assign w_q_ext = {1'b0, i_q};

    // Step one position in the requested direction, wrapping at the bounds.
    always_comb begin
        o_next     = i_q;
        o_at_bound = 1'b0;
        case (i_up_dn)
            DIR_UP: begin
                if (w_q_ext == MAX_W) begin
                    o_next     = ZERO_Q;
                    o_at_bound = 1'b1;
                end else begin
                    o_next     = WIDTH'(w_q_ext + ONE_W);
                    o_at_bound = 1'b0;
                end
            end
            DIR_DN: begin
                if (w_q_ext == ZERO_W) begin
                    o_next     = MAX_Q;
                    o_at_bound = 1'b1;
                end else begin
                    o_next     = WIDTH'(w_q_ext - ONE_W);
                    o_at_bound = 1'b0;
                end
            end
            default: begin
                o_next     = i_q;
                o_at_bound = 1'b0;
            end
        endcase
    end

endmodule : updown_next

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//   Fully synchronous up/down modulo counter with programmable modulus,
//   synchronous parallel load (clamped into range), count enable, runtime
//   direction and a registered wrap pulse.
//
//   Priority at each rising clk edge: reset > load > en > hold.
//
//   Build option COUNTER_SAT_EN:
//     undefined (default) - modulo wrap; wrap pulses on the wrapped value,
//                           sat is tied to 0.
//     defined             - saturating; the counter sticks at 0 / MODULUS-1,
//                           sat is high while a step is refused at a bound,
//                           wrap is tied to 0.
//   The port list is identical in both builds.
//
//   A single flag register carries wrap (modulo build) or sat (saturating
//   build); the other output is a constant 0.
// ---------------------------------------------------------------------------
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             sat
);

    // Reject illegal configurations at elaboration time.
    generate
        if ((WIDTH < 1) || (WIDTH > CNT_MAX_WIDTH)) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be in 1..32");
        end
        if ((MODULUS < 2) || (MODULUS > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    // Largest legal count, held at clamp-helper width.
    localparam logic [31:0]      MAX32  = 32'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_q;
    logic             r_flag;

    logic [WIDTH-1:0] w_next;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_flag_nxt;

    // Next value for a single counting step (wrap-around arithmetic).
    updown_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_q        (r_q),
        .i_up_dn    (up_dn),
        .o_next     (w_next),
        .o_at_bound (w_at_bound)
    );

    // Out-of-range load values collapse to the top of the count range.
    assign w_load_clamped = WIDTH'(clamp_load(32'(load_val), MAX32));

    // Priority mux below reset: load > en > hold.
    always_comb begin
        w_q_nxt    = r_q;
        w_flag_nxt = 1'b0;
        if (load) begin
            w_q_nxt    = w_load_clamped;
            w_flag_nxt = 1'b0;
        end else if (en) begin
`ifdef COUNTER_SAT_EN
            // At a bound the step is refused and the refusal is flagged.
            if (w_at_bound) begin
                w_q_nxt    = r_q;
                w_flag_nxt = 1'b1;
            end else begin
                w_q_nxt    = w_next;
                w_flag_nxt = 1'b0;
            end
`else
            // Stepping across a bound wraps and raises the one-cycle pulse.
            w_q_nxt    = w_next;
            w_flag_nxt = w_at_bound;
`endif
        end else begin
            w_q_nxt    = r_q;
            w_flag_nxt = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= ZERO_Q;
            r_flag <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_flag <= w_flag_nxt;
        end
    end

    assign q = r_q;

`ifdef COUNTER_SAT_EN
    assign wrap = 1'b0;
    assign sat  = r_flag;
`else
    assign wrap = r_flag;
    assign sat  = 1'b0;
`endif

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
//   Directed plus random bench for updown_mod_counter (WIDTH=4, MODULUS=10).
//   A behavioural model predicts q/wrap/sat whenever inputs are driven; the
//   prediction is queued and compared after the following rising edge.
//   Honours COUNTER_SAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;
`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             sat;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             wrap;
        logic             sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_q    = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .wrap     (wrap),
        .sat      (sat)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pop the oldest prediction and compare it with the DUT outputs.
    task automatic compare();
        exp_t x;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            x = exp_q.pop_front();
            checks++;
            assert (q === x.q) else begin
                errors++;
                $error("FAIL q: observed %0d expected %0d", q, x.q);
            end
            checks++;
            assert (wrap === x.wrap) else begin
                errors++;
                $error("FAIL wrap: observed %b expected %b (q=%0d)", wrap, x.wrap, q);
            end
            checks++;
            assert (sat === x.sat) else begin
                errors++;
                $error("FAIL sat: observed %b expected %b (q=%0d)", sat, x.sat, q);
            end
        end
    endtask

    // Drive one cycle of inputs, predict the result, clock, then compare.
    task automatic drive(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                         input logic e, input logic ud);
        exp_t x;
        int   nq;
        logic nw;
        logic ns;
        reset    = r;
        load     = ld;
        load_val = lv;
        en       = e;
        up_dn    = ud;
        nq = m_q;
        nw = 1'b0;
        ns = 1'b0;
        if (r) begin
            nq = 0;
        end else if (ld) begin
            nq = (int'(lv) >= MODULUS) ? MODULUS - 1 : int'(lv);
        end else if (e) begin
            if (ud) begin
                if (m_q == MODULUS - 1) begin
                    if (SAT) ns = 1'b1;
                    else begin nq = 0; nw = 1'b1; end
                end else nq = m_q + 1;
            end else begin
                if (m_q == 0) begin
                    if (SAT) ns = 1'b1;
                    else begin nq = MODULUS - 1; nw = 1'b1; end
                end else nq = m_q - 1;
            end
        end
        m_q    = nq;
        x.q    = nq[WIDTH-1:0];
        x.wrap = nw;
        x.sat  = ns;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        int   wraps;
        int   exp_dn[4];
        int   exp_tg[4];
        logic ud;
        exp_dn = '{1, 0, 9, 8};
        exp_tg = '{6, 5, 6, 5};

        // 1. Reset, count a little, then reset while load and en are high.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        chk("reset_q", int'(q), 0);

        // 2. Count up through three full periods.
        wraps = 0;
        for (int i = 0; i < 3 * MODULUS; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            if (wrap === 1'b1) wraps++;
        end
`ifndef COUNTER_SAT_EN
        chk("wrap_count", wraps, 3);
        chk("up_end_q", int'(q), 0);
`endif

        // 3. Load 2 then count down across zero.
        drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("load2_q", int'(q), 2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
`ifndef COUNTER_SAT_EN
            chk("down_q", int'(q), exp_dn[i]);
`endif
        end

        // 4. Load has priority over en and clamps out-of-range values.
        drive(1'b0, 1'b1, 4'd13, 1'b1, 1'b1);
        chk("clamp13_q", int'(q), 9);
        drive(1'b0, 1'b1, 4'd10, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4'd15, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        chk("load5_q", int'(q), 5);

        // 5. Hold for four cycles, then flip direction every cycle.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 4'd3, 1'b0, 1'(i % 2));
        chk("hold_q", int'(q), 5);
        ud = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b1, ud);
            chk("toggle_q", int'(q), exp_tg[i]);
            ud = ~ud;
        end

`ifdef COUNTER_SAT_EN
        // 6. Saturating build: stick at the bounds and flag it.
        drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("sat_up_q", int'(q), 9);
        chk("sat_up_flag", int'(sat), 1);
        drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("sat_dn_q", int'(q), 0);
        chk("sat_dn_flag", int'(sat), 1);
`endif

        // Random mix of all controls, checked against the model.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 7) == 0),
                  WIDTH'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_updown_mod_counter
